// File: rtl/aes_decrypt_core.sv
// aes_decrypt_core: iterative AES-128 inverse cipher, one round per clock, round keys supplied externally.
// Ports:
//   clk            - rising-edge clock
//   reset_n        - asynchronous active-low reset
//   cipher_text    - 128-bit ciphertext, sampled on an accepted start
//   round_key      - 128-bit round key for index round_num, valid in the same cycle
//   decrypt_new_en - single-cycle start request, honoured only while idle
//   round_key_en   - high on every key-consuming cycle (accept cycle plus RUN)
//   plain_ready    - high while idle; plain_text then holds the last result
//   plain_done     - one-cycle pulse when a result becomes valid
//   round_num      - round-key index needed this cycle (10 when idle, 9..0 while running)
//   plain_text     - the state register itself
module aes_decrypt_core (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [127:0] cipher_text,
    input  logic [127:0] round_key,
    input  logic         decrypt_new_en,
    output logic         round_key_en,
    output logic         plain_ready,
    output logic         plain_done,
    output logic [3:0]   round_num,
    output logic [127:0] plain_text
);
    typedef enum logic {IDLE, RUN} fsm_t;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) multiply by a 4-bit constant, built from repeated doubling
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xt(a);
        x4 = xt(x2);
        x8 = xt(x4);
        return (k[0] ? a : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9),
                gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd),
                gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb),
                gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he)};
    endfunction

    fsm_t         fsm_q;
    logic [3:0]   cnt_q;
    logic [127:0] data_q, data_d, sub_w, key_w, mix_w;
    logic         ready_q, done_q;

    // Byte (row r, column c) sits at index 4c+r, byte 0 in the top bits.
    // InvShiftRows pulls row r from column (c - r) mod 4.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sub_w[127-8*(4*c+r) -: 8] = INV_SBOX[data_q[127-8*(4*((c-r+4)%4)+r) -: 8]];
        end
        assign mix_w[127-32*c -: 32] = inv_mix(key_w[127-32*c -: 32]);
    end

    assign key_w  = sub_w ^ round_key;
    assign data_d = (cnt_q == 4'd0) ? key_w : mix_w;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q   <= IDLE;
            cnt_q   <= 4'hA;
            data_q  <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (fsm_q)
                IDLE: if (decrypt_new_en) begin
                    data_q  <= cipher_text ^ round_key;
                    cnt_q   <= 4'd9;
                    ready_q <= 1'b0;
                    fsm_q   <= RUN;
                end
                RUN: begin
                    data_q <= data_d;
                    if (cnt_q == 4'd0) begin
                        cnt_q   <= 4'hA;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                        fsm_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    // The accept cycle already consumes round key 10, so it counts as a key cycle
    assign round_key_en = (fsm_q == RUN) | ((fsm_q == IDLE) & decrypt_new_en);
    assign plain_ready  = ready_q;
    assign plain_done   = done_q;
    assign round_num    = cnt_q;
    assign plain_text   = data_q;
endmodule

// File: tb/tb_aes_decrypt_core.sv
// tb_aes_decrypt_core: directed and loopback checks of aes_decrypt_core with a bench-side key schedule.
module tb_aes_decrypt_core;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         decrypt_new_en = 1'b0;
    logic [127:0] cipher_text = '0;
    logic [127:0] round_key;
    logic         round_key_en, plain_ready, plain_done;
    logic [3:0]   round_num;
    logic [127:0] plain_text;

    logic [127:0] rk [16];
    logic [7:0]   sbox [256];
    int           total = 0;
    int           bad = 0;

    aes_decrypt_core dut (
        .clk(clk),
        .reset_n(reset_n),
        .cipher_text(cipher_text),
        .round_key(round_key),
        .decrypt_new_en(decrypt_new_en),
        .round_key_en(round_key_en),
        .plain_ready(plain_ready),
        .plain_done(plain_done),
        .round_num(round_num),
        .plain_text(plain_text)
    );

    always #5 clk = ~clk;

    // Key-schedule memory: serves whichever round key the core asks for
    assign round_key = rk[round_num];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    // Forward S-box derived from the field inverse plus affine map
    task automatic init_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h01;
            repeat (254) inv = gmul(inv, 8'(a));
            if (a == 0) inv = 8'h00;
            sbox[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic set_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rcon, 24'h0};
                rcon = xtime(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) rk[r] = (r < 11) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] v;
        v = pt ^ rk[0];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox[v[127-8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
            for (int c = 0; c < 4; c++) begin
                if (rd < 10) begin
                    s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                    s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
                end else begin
                    for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
                end
            end
            for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i];
            v = v ^ rk[rd];
        end
        return v;
    endfunction

    task automatic do_start(input logic [127:0] ct, input logic [127:0] key);
        set_key(key);
        cipher_text = ct;
        decrypt_new_en = 1'b1;
    endtask

    // Called at the negedge where a start is driven; returns at the negedge where plain_ready is seen.
    // Optionally checks the round_num sequence and injects a start request at round_num == pulse_at.
    task automatic wait_result(input logic [127:0] exp, input string name, input bit chk_rn,
                               input int pulse_at, input logic [127:0] pulse_ct);
        int n;
        bit pulsed;
        n = 0;
        pulsed = 1'b0;
        do begin
            @(negedge clk);
            n++;
            decrypt_new_en = 1'b0;
            if (n == 1) begin
                total++;
                if (plain_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL %s_busy: plain_ready got %b want 0", name, plain_ready);
                end
            end
            if (chk_rn) begin
                total++;
                if (round_num !== ((n >= 11) ? 4'hA : 4'(10 - n))) begin
                    bad++;
                    $display("FAIL %s_round_num: edge %0d got %0d want %0d", name, n, round_num,
                             (n >= 11) ? 10 : 10 - n);
                end
            end
            if (!pulsed && pulse_at >= 0 && !plain_ready && int'(round_num) == pulse_at) begin
                decrypt_new_en = 1'b1;
                cipher_text = pulse_ct;
                pulsed = 1'b1;
            end
        end while (!plain_ready && n < 30);
        total++;
        if (n != 11) begin
            bad++;
            $display("FAIL %s_latency: got %0d edges want 11", name, n);
        end
        total++;
        if (plain_text !== exp) begin
            bad++;
            $display("FAIL %s_plain_text: got %h want %h", name, plain_text, exp);
        end
        total++;
        if (plain_done !== 1'b1) begin
            bad++;
            $display("FAIL %s_done: got %b want 1", name, plain_done);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({plain_text, plain_ready, plain_done, round_num, round_key_en} !== {128'h0, 1'b1, 1'b0, 4'hA, 1'b0}) begin
            bad++;
            $display("FAIL reset_values: got text=%h rdy=%b done=%b rn=%0d rke=%b want 0/1/0/10/0",
                     plain_text, plain_ready, plain_done, round_num, round_key_en);
        end
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if ({plain_ready, round_num} !== {1'b1, 4'hA}) begin
            bad++;
            $display("FAIL reset_release: got rdy=%b rn=%0d want 1/10", plain_ready, round_num);
        end
    endtask

    task automatic test_fips_c1();
        @(negedge clk);
        do_start(C1_CT, C1_KEY);
        #1;
        total++;
        if (round_key_en !== 1'b1) begin
            bad++;
            $display("FAIL c1_accept_key_en: got %b want 1", round_key_en);
        end
        wait_result(C1_PT, "c1", 1'b0, -1, '0);
        @(negedge clk);
        total++;
        if ({plain_done, round_key_en, plain_ready} !== 3'b001) begin
            bad++;
            $display("FAIL c1_after_done: got done=%b rke=%b rdy=%b want 0/0/1", plain_done, round_key_en, plain_ready);
        end
        total++;
        if (plain_text !== C1_PT) begin
            bad++;
            $display("FAIL c1_hold: got %h want %h", plain_text, C1_PT);
        end
    endtask

    task automatic test_app_b();
        @(negedge clk);
        total++;
        if (round_num !== 4'hA) begin
            bad++;
            $display("FAIL appb_rn_start: got %0d want 10", round_num);
        end
        do_start(B_CT, B_KEY);
        wait_result(B_PT, "appb", 1'b1, -1, '0);
    endtask

    task automatic test_ignore_busy();
        @(negedge clk);
        do_start(C1_CT, C1_KEY);
        wait_result(C1_PT, "ignore", 1'b0, 5, B_CT);
        repeat (2) @(negedge clk);
        total++;
        if ({plain_ready, plain_text} !== {1'b1, C1_PT}) begin
            bad++;
            $display("FAIL ignore_no_queue: got rdy=%b text=%h want 1/%h", plain_ready, plain_text, C1_PT);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        do_start(C1_CT, C1_KEY);
        wait_result(C1_PT, "b2b_first", 1'b0, -1, '0);
        do_start(B_CT, B_KEY);
        wait_result(B_PT, "b2b_second", 1'b0, -1, '0);
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clk);
        do_start(C1_CT, C1_KEY);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            decrypt_new_en = 1'b0;
        end while (round_num !== 4'd4 && n < 20);
        total++;
        if (round_num !== 4'd4) begin
            bad++;
            $display("FAIL rst_mid_reach: got rn=%0d want 4", round_num);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if ({plain_text, plain_ready, plain_done, round_num} !== {128'h0, 1'b1, 1'b0, 4'hA}) begin
            bad++;
            $display("FAIL rst_mid_values: got text=%h rdy=%b done=%b rn=%0d want 0/1/0/10",
                     plain_text, plain_ready, plain_done, round_num);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_start(C1_CT, C1_KEY);
        wait_result(C1_PT, "rst_mid_rerun", 1'b0, -1, '0);
    endtask

    task automatic test_loopback();
        logic [127:0] key, pt, ct;
        for (int i = 0; i < 100; i++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            set_key(key);
            ct = encrypt(pt);
            @(negedge clk);
            do_start(ct, key);
            wait_result(pt, "loopback", 1'b0, -1, '0);
        end
    endtask

    initial begin
        for (int r = 0; r < 16; r++) rk[r] = '0;
        init_sbox();
        test_reset();
        test_fips_c1();
        test_app_b();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        test_loopback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/aes_decrypt_core.md
AES_DECRYPT_CORE -- requirements
Module: aes_decrypt_core

Interface
REQ-001 The block SHALL have a single clock, clk (1 bit, input, rising-edge).
REQ-002 The block SHALL have reset_n (1 bit, input): asynchronous, active-low reset.
REQ-003 The block SHALL have cipher_text (128 bits, input): the ciphertext block, sampled on an accepted start.
REQ-004 The block SHALL have round_key (128 bits, input): the expanded round key for index round_num, valid in the same cycle.
REQ-005 The block SHALL have decrypt_new_en (1 bit, input): start request, a single-cycle pulse.
REQ-006 The block SHALL have round_key_en (1 bit, output): high while the core is consuming round keys, equal to ~plain_ready.
REQ-007 The block SHALL have plain_ready (1 bit, output): high when idle and plain_text is valid.
REQ-008 The block SHALL have plain_done (1 bit, output): one-cycle pulse in the cycle that plain_ready rises.
REQ-009 The block SHALL have round_num (4 bits, output): the round-key index required this cycle.
REQ-010 The block SHALL have plain_text (128 bits, output): the state register, driven directly with no output logic.

Function
REQ-011 The block SHALL implement AES-128 inverse cipher (FIPS-197 sec. 5.3), one round per clock, iterative, with no key expansion inside.
REQ-012 The block SHALL have states IDLE and RUN.
- IDLE -> RUN when decrypt_new_en=1.
- RUN -> IDLE when the counter is 0 and the final round completes.
REQ-013 The counter SHALL be 4 bits, and round_num SHALL equal the counter.
- In IDLE the counter holds 10 (4'hA).
- In RUN the counter decrements by 1 per cycle, from 9 down to 0.
REQ-014 On the accepting edge in IDLE with decrypt_new_en=1:
- state <= cipher_text ^ round_key, using the key at round_num=10.
- counter <= 9.
- plain_ready <= 0.
REQ-015 In RUN with counter=k, k in 9..1: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ round_key).
REQ-016 In RUN with counter=0:
- state <= InvSubBytes(InvShiftRows(state)) ^ round_key.
- counter <= 10.
- plain_ready <= 1.
- plain_done <= 1 for exactly one cycle.
REQ-017 Latency SHALL be 11 rising edges, counted from the edge sampling decrypt_new_en to the edge after which plain_ready=1 and plain_text is valid.
REQ-018 decrypt_new_en asserted in RUN SHALL be ignored: no restart, no corruption, and no queuing.
REQ-019 decrypt_new_en asserted in the same cycle as plain_done SHALL be accepted as a new start.
- The result of the previous block remains visible for that one cycle only.
REQ-020 In IDLE, plain_text SHALL hold its last value until the next accepted start.
REQ-021 InvSubBytes SHALL use the FIPS-197 inverse S-box, combinational.
REQ-022 InvMixColumns SHALL use GF(2^8) multiplication by {0e,0b,0d,09} modulo x^8+x^4+x^3+x+1.
REQ-023 Byte ordering SHALL be as follows:
- Bit [127:120] is state byte 0.
- Bytes are column-major.
- Byte ordering is identical on cipher_text, round_key and plain_text.
REQ-024 round_key_en SHALL be high on all 11 key-consuming cycles.
- This covers the accepting IDLE cycle plus the RUN cycles for k = 9..0.
- round_key_en is therefore defined as (IDLE & decrypt_new_en) | RUN.
- This definition overrides REQ-006 for the accept cycle.

Reset
REQ-025 When reset_n=0, the block SHALL immediately (asynchronously) apply the reset values:
- state machine = IDLE
- counter = 10
- plain_text = 128'h0
- plain_ready = 1
- plain_done = 0
- round_key_en = 0
- round_num = 4'hA
REQ-026 Reset asserted mid-RUN SHALL abort the operation with no partial result retained.
- After reset_n deasserts, the next decrypt_new_en SHALL start cleanly.

Verification
REQ-027 The bench SHALL cover FIPS-197 C.1.
- Stimulus: key 000102030405060708090a0b0c0d0e0f, cipher_text 69c4e0d86a7b0430d8cdb78070b4c55a.
- Required response: plain_text 00112233445566778899aabbccddeeff exactly 11 edges after the start, with plain_done high for one cycle.
REQ-028 The bench SHALL cover FIPS-197 App. B.
- Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, cipher_text 3925841d02dc09fbdc118597196a0b32.
- Required response: plain_text 3243f6a8885a308d313198a2e0370734.
- The bench SHALL also check that round_num steps through the sequence 10, 9, 8, ..., 0, 10.
REQ-029 The bench SHALL cover a start ignored while busy.
- Stimulus: pulse decrypt_new_en at round_num=5 with a different cipher_text.
- Required response: the C.1 result is unchanged and the latency is still 11.
REQ-030 The bench SHALL cover back-to-back operation.
- Stimulus: decrypt_new_en in the plain_done cycle with the App. B vector.
- Required response: the C.1 result is visible for 1 cycle, then the App. B result follows 11 edges later.
REQ-031 The bench SHALL cover reset mid-operation.
- Stimulus: assert reset_n=0 at round_num=4.
- Required response: plain_text=0, plain_ready=1 and round_num=10 immediately.
- A subsequent C.1 run SHALL then pass.
REQ-032 The bench SHALL cover loopback.
- Stimulus: feed the output of the encrypt core, for 100 random key/plaintext pairs, into this block.
- Required response: the recovered plaintext equals the original in every case.
